uart_tx_gen: RTL

Parametrised successor of the fixed 8N1 UART transmitter.
- Configurable data width, parity mode and stop-bit count.
- valid/ready input handshake.
- Single-cycle done pulse.
- Optional one-entry holding register for back-to-back frames.
- Sits between a byte/word producer (CPU bridge, packetiser) and the board TX pin.

---
 rtl/uart_tx_gen_pkg.sv | 40 ++++
 rtl/uart_tx_gen_bit_timer.sv | 31 +++
 rtl/uart_tx_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_gen_pkg.sv
// Shared state encoding, parity constants and elaboration helpers for uart_tx_gen.
package uart_tx_gen_defs;

   typedef enum logic [5:0] {
      ST_IDLE   = 6'b000001,
      ST_START  = 6'b000010,
      ST_DATA   = 6'b000100,
      ST_PARITY = 6'b001000,
      ST_STOP   = 6'b010000,
      ST_FINAL  = 6'b100000
   } status_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int bit_clocks(input int clk_khz, input int baud_bps);
      return int'((longint'(clk_khz) * 1000) / longint'(baud_bps));
   endfunction

   function automatic string to_string(input status_e s);
      case (s)
         ST_IDLE:   return "Idle";
         ST_START:  return "StartBit";
         ST_DATA:   return "DataBits";
         ST_PARITY: return "ParityBit";
         ST_STOP:   return "StopBits";
         ST_FINAL:  return "Finalize";
         default:   return "Unknown";
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_gen_bit_timer.sv
// Bit-period counter: tick marks the last clock of each bit while run is high.
module uart_bit_timer
   import uart_tx_gen_defs::*;
#(
   parameter int BIT_CLOCKS = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = clog2(BIT_CLOCKS);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == CW'(BIT_CLOCKS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) cnt_d = '0;
      else if (run)      cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter with valid/ready input and registered outputs.
// Define UART_TX_GEN_HOLD_EN to add a one-entry holding register for gapless frames.
module uart_tx_gen
   import uart_tx_gen_defs::*;
#(
   parameter int CLK_FREQ_KHz  = 50000,
   parameter int BAUD_RATE_BPS = 115200,
   parameter int DATA_WIDTH    = 8,
   parameter int PARITY_MODE   = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  data_ready,
   output logic                  tx,
   output logic                  tx_en,
   output logic                  tx_done
);

   localparam int BIT_CLOCKS = bit_clocks(CLK_FREQ_KHz, BAUD_RATE_BPS);
   localparam int DBW        = clog2(DATA_WIDTH);

   if (BIT_CLOCKS < 2) begin : g_bad_baud
      $error("uart_tx_gen: BIT_CLOCKS must be at least 2");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_tx_gen: DATA_WIDTH must be 5..9");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
      $error("uart_tx_gen: bad PARITY_MODE or STOP_BITS");
   end

   status_e               state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
   logic [DBW-1:0]        dcnt_q, dcnt_d;
   logic                  stop_q, stop_d, par_q, par_d, hold_full_q, hold_full_d;
   logic                  rdy_q, rdy_d, tx_q, tx_d, tx_en_q, tx_en_d, tx_done_q, tx_done_d;
   logic                  tick, run, accept, load, entry;
`ifdef UART_TX_GEN_HOLD_EN
   logic                  chain_q, chain_d;
`endif

   assign run    = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
   assign accept = data_en && rdy_q;
   assign entry  = state_d != state_q;
   assign load   = (state_d == ST_START) && (state_q != ST_START);

   uart_bit_timer #(.BIT_CLOCKS(BIT_CLOCKS)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (entry),
      .run   (run),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (hold_full_q) state_d = ST_START;
         ST_START:  if (tick) state_d = ST_DATA;
         ST_DATA:   if (tick && dcnt_q == DBW'(DATA_WIDTH - 1))
                       state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (tick) state_d = ST_STOP;
         ST_STOP:   if (tick && (STOP_BITS == 1 || stop_q)) begin
`ifdef UART_TX_GEN_HOLD_EN
                       state_d = hold_full_q ? ST_START : ST_FINAL;
`else
                       state_d = ST_FINAL;
`endif
                    end
         ST_FINAL:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Accepted words always land in hold first; a frame starts by draining it.
   always_comb begin
      shift_d     = shift_q;
      par_d       = par_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      dcnt_d      = dcnt_q;
      stop_d      = stop_q;
      if (load) begin
         shift_d     = hold_q;
         par_d       = (^hold_q) ^ (PARITY_MODE == PARITY_ODD);
         hold_full_d = 1'b0;
      end else if (state_q == ST_DATA && tick) begin
         shift_d = shift_q >> 1;
      end
      if (accept) begin
         hold_d      = data;
         hold_full_d = 1'b1;
      end
      if (entry) begin
         dcnt_d = '0;
         stop_d = 1'b0;
      end else begin
         if (state_q == ST_DATA && tick) dcnt_d = dcnt_q + 1'b1;
         if (state_q == ST_STOP && tick) stop_d = ~stop_q;
      end
`ifdef UART_TX_GEN_HOLD_EN
      rdy_d   = !hold_full_d;
      chain_d = (state_q == ST_STOP) && (state_d == ST_START);
`else
      rdy_d   = (state_d == ST_IDLE) && !hold_full_d;
`endif
   end

   always_comb begin
      tx_d      = 1'b1;
      tx_en_d   = 1'b0;
      tx_done_d = 1'b0;
      unique case (state_q)
         ST_START:  begin tx_d = 1'b0;       tx_en_d = 1'b1; end
         ST_DATA:   begin tx_d = shift_q[0]; tx_en_d = 1'b1; end
         ST_PARITY: begin tx_d = par_q;      tx_en_d = 1'b1; end
         ST_STOP:   tx_en_d = 1'b1;
         ST_FINAL:  tx_done_d = 1'b1;
         default:   ;
      endcase
`ifdef UART_TX_GEN_HOLD_EN
      if (chain_q) tx_done_d = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         par_q       <= 1'b0;
         dcnt_q      <= '0;
         stop_q      <= 1'b0;
         rdy_q       <= 1'b1;
         tx_q        <= 1'b1;
         tx_en_q     <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         par_q       <= par_d;
         dcnt_q      <= dcnt_d;
         stop_q      <= stop_d;
         rdy_q       <= rdy_d;
         tx_q        <= tx_d;
         tx_en_q     <= tx_en_d;
         tx_done_q   <= tx_done_d;
      end
   end

`ifdef UART_TX_GEN_HOLD_EN
   always_ff @(posedge clk) begin
      if (!rst) chain_q <= 1'b0;
      else      chain_q <= chain_d;
   end
`endif

   assign data_ready = rdy_q;
   assign tx         = tx_q;
   assign tx_en      = tx_en_q;
   assign tx_done    = tx_done_q;

endmodule
